// File: rtl/cms_pix28_package.sv
// Shared definitions for the pix28 firmware command path: op codes, status bit map,
// test numbers, firmware ids and the dispatcher FSM state type.
package cms_pix28_package;

  typedef enum logic [3:0] {
    OpNoop           = 4'h0,
    OpWRstFw         = 4'h1,
    OpWCfgStatic0    = 4'h2,
    OpRCfgStatic0    = 4'h3,
    OpWCfgStatic1    = 4'h4,
    OpRCfgStatic1    = 4'h5,
    OpWCfgArray0     = 4'h6,
    OpRCfgArray0     = 4'h7,
    OpWCfgArray1     = 4'h8,
    OpRCfgArray1     = 4'h9,
    OpWCfgArray2     = 4'hA,
    OpRCfgArray2     = 4'hB,
    OpRDataArray0    = 4'hC,
    OpRDataArray1    = 4'hD,
    OpWStatusFwClear = 4'hE,
    OpWExecute       = 4'hF
  } op_code_e;

  typedef enum logic [1:0] {StIdle, StRun, StDone} fw_state_e;

  localparam int unsigned status_index_op_code_w_rst_fw         = 0;
  localparam int unsigned status_index_op_code_w_cfg_static_0   = 1;
  localparam int unsigned status_index_op_code_r_cfg_static_0   = 2;
  localparam int unsigned status_index_op_code_w_cfg_static_1   = 3;
  localparam int unsigned status_index_op_code_r_cfg_static_1   = 4;
  localparam int unsigned status_index_op_code_w_cfg_array_0    = 5;
  localparam int unsigned status_index_op_code_r_cfg_array_0    = 6;
  localparam int unsigned status_index_op_code_w_cfg_array_1    = 7;
  localparam int unsigned status_index_op_code_r_cfg_array_1    = 8;
  localparam int unsigned status_index_op_code_w_cfg_array_2    = 9;
  localparam int unsigned status_index_op_code_r_cfg_array_2    = 10;
  localparam int unsigned status_index_op_code_r_data_array_0   = 11;
  localparam int unsigned status_index_op_code_r_data_array_1   = 12;
  localparam int unsigned status_index_op_code_w_execute        = 13;
  localparam int unsigned status_index_test1_done               = 14;
  localparam int unsigned status_index_test2_done               = 15;
  localparam int unsigned status_index_test3_done               = 16;
  localparam int unsigned status_index_test4_done               = 17;
  localparam int unsigned status_index_test5_done               = 18;
  localparam int unsigned status_index_error_w_execute_cfg      = 31;

  localparam logic [3:0] test_number_1 = 4'h1;
  localparam logic [3:0] test_number_2 = 4'h2;
  localparam logic [3:0] test_number_3 = 4'h4;
  localparam logic [3:0] test_number_4 = 4'h8;
  localparam logic [3:0] test_number_5 = 4'h3;

  localparam logic [3:0] firmware_id_1 = 4'h1;
  localparam logic [3:0] firmware_id_2 = 4'h2;
  localparam logic [3:0] firmware_id_3 = 4'h4;
  localparam logic [3:0] firmware_id_4 = 4'h8;

  function automatic logic test_number_valid(logic [3:0] tn);
    return (tn == test_number_1) || (tn == test_number_2) || (tn == test_number_3) ||
           (tn == test_number_4) || (tn == test_number_5);
  endfunction

  function automatic logic [4:0] test_done_index(logic [3:0] tn);
    logic [4:0] idx;
    idx = 5'(status_index_test1_done);
    case (tn)
      test_number_2: idx = 5'(status_index_test2_done);
      test_number_3: idx = 5'(status_index_test3_done);
      test_number_4: idx = 5'(status_index_test4_done);
      test_number_5: idx = 5'(status_index_test5_done);
      default:       idx = 5'(status_index_test1_done);
    endcase
    return idx;
  endfunction

  // NOOP, W_RST_FW and W_STATUS_FW_CLEAR leave no op-code trace in status.
  function automatic logic op_sets_status(op_code_e op);
    return !(op inside {OpNoop, OpWRstFw, OpWStatusFwClear});
  endfunction

  function automatic logic [4:0] op_status_index(op_code_e op);
    logic [4:0] idx;
    case (op)
      OpWCfgStatic0: idx = 5'(status_index_op_code_w_cfg_static_0);
      OpRCfgStatic0: idx = 5'(status_index_op_code_r_cfg_static_0);
      OpWCfgStatic1: idx = 5'(status_index_op_code_w_cfg_static_1);
      OpRCfgStatic1: idx = 5'(status_index_op_code_r_cfg_static_1);
      OpWCfgArray0:  idx = 5'(status_index_op_code_w_cfg_array_0);
      OpRCfgArray0:  idx = 5'(status_index_op_code_r_cfg_array_0);
      OpWCfgArray1:  idx = 5'(status_index_op_code_w_cfg_array_1);
      OpRCfgArray1:  idx = 5'(status_index_op_code_r_cfg_array_1);
      OpWCfgArray2:  idx = 5'(status_index_op_code_w_cfg_array_2);
      OpRCfgArray2:  idx = 5'(status_index_op_code_r_cfg_array_2);
      OpRDataArray0: idx = 5'(status_index_op_code_r_data_array_0);
      OpRDataArray1: idx = 5'(status_index_op_code_r_data_array_1);
      OpWExecute:    idx = 5'(status_index_op_code_w_execute);
      default:       idx = 5'(status_index_op_code_w_rst_fw);
    endcase
    return idx;
  endfunction

  // 0..2 select cfg_array_0..2, 3..4 select data_array_0..1.
  function automatic logic [2:0] array_sel(op_code_e op);
    logic [2:0] sel;
    case (op)
      OpWCfgArray1, OpRCfgArray1: sel = 3'd1;
      OpWCfgArray2, OpRCfgArray2: sel = 3'd2;
      OpRDataArray0:              sel = 3'd3;
      OpRDataArray1:              sel = 3'd4;
      default:                    sel = 3'd0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fw_cmd_watchdog.sv
// Execute watchdog: counts up while enabled, flags the cycle whose increment lands on
// all-ones so the owner reacts on the same edge the counter saturates.
module fw_cmd_watchdog #(
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_W-1:0] CntOne  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] CntLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i & ~clear_i & (cnt_q == CntLast);

endmodule

// File: rtl/fw_cmd_dispatcher.sv
// Firmware command dispatcher: decodes id-matched command words into config latches,
// read-back, array strobes and a test-execute FSM with watchdog and sticky status.
module fw_cmd_dispatcher
  import cms_pix28_package::*;
#(
  parameter int unsigned TIMEOUT_W = 24,
  parameter logic [3:0]  FW_ID     = firmware_id_1
) (
  input  logic        fw_axi_clk,
  input  logic        fw_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_word,
  output logic [23:0] cfg_static_0_reg,
  output logic [23:0] cfg_static_1_reg,
  output logic [23:0] execute_cfg_reg,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        arr_wr,
  output logic        arr_rd,
  output logic [2:0]  arr_sel,
  output logic [23:0] arr_body,
  output logic        test_start,
  output logic        test_abort,
  input  logic        test_done,
  output logic [31:0] status_reg
);

  fw_state_e   state_q, state_d;
  logic        ready_q;
  logic [23:0] cfg0_q, cfg0_d, cfg1_q, cfg1_d, exec_q, exec_d, arr_body_q, arr_body_d;
  logic [31:0] rd_data_q, rd_data_d, status_q, status_d;
  logic        rd_valid_q, rd_valid_d, arr_wr_q, arr_wr_d, arr_rd_q, arr_rd_d;
  logic [2:0]  arr_sel_q, arr_sel_d;
  logic        start_q, start_d, abort_q, abort_d;
  logic [3:0]  run_tn_q, run_tn_d;

  logic        accept, matched, exec_cmd, rst_cmd, tn_ok, running, wd_expired;
  op_code_e    op;
  logic [23:0] body;
  logic [3:0]  tn;

  assign accept   = cmd_valid & ready_q;
  assign matched  = accept & |(cmd_word[31:28] & FW_ID);
  assign op       = op_code_e'(cmd_word[27:24]);
  assign body     = cmd_word[23:0];
  assign tn       = body[15:12];
  assign tn_ok    = test_number_valid(tn);
  assign exec_cmd = matched & (op == OpWExecute);
  assign rst_cmd  = matched & (op == OpWRstFw);
  assign running  = (state_q == StRun);

  fw_cmd_watchdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_watchdog (
    .clk_i    (fw_axi_clk),
    .rst_i    (fw_rst),
    .clear_i  (!running),
    .enable_i (running),
    .expired_o(wd_expired)
  );

  always_ff @(posedge fw_axi_clk or posedge fw_rst) begin
    if (fw_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (exec_cmd && tn_ok) state_d = StRun;
      StRun: begin
        if (test_done) begin
          state_d = StDone;
        end else if (wd_expired) begin
          state_d = StIdle;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (rst_cmd) state_d = StIdle;
  end

  always_comb begin
    cfg0_d     = cfg0_q;
    cfg1_d     = cfg1_q;
    exec_d     = exec_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    arr_wr_d   = 1'b0;
    arr_rd_d   = 1'b0;
    arr_sel_d  = arr_sel_q;
    arr_body_d = arr_body_q;
    start_d    = 1'b0;
    abort_d    = 1'b0;
    run_tn_d   = run_tn_q;
    status_d   = status_q;
    if (matched) begin
      unique case (op)
        OpWStatusFwClear: status_d = '0;
        OpWCfgStatic0:    cfg0_d = body;
        OpWCfgStatic1:    cfg1_d = body;
        OpRCfgStatic0: begin
          rd_data_d  = {8'h00, cfg0_q};
          rd_valid_d = 1'b1;
        end
        OpRCfgStatic1: begin
          rd_data_d  = {8'h00, cfg1_q};
          rd_valid_d = 1'b1;
        end
        OpWCfgArray0, OpWCfgArray1, OpWCfgArray2: begin
          arr_wr_d   = 1'b1;
          arr_sel_d  = array_sel(op);
          arr_body_d = body;
        end
        OpRCfgArray0, OpRCfgArray1, OpRCfgArray2, OpRDataArray0, OpRDataArray1: begin
          arr_rd_d   = 1'b1;
          arr_sel_d  = array_sel(op);
          arr_body_d = body;
        end
        OpWExecute: begin
          if (state_q == StIdle) begin
            exec_d = body;
            if (tn_ok) begin
              start_d  = 1'b1;
              run_tn_d = tn;
            end
          end
        end
        default: ;
      endcase
      if (op_sets_status(op)) status_d[op_status_index(op)] = 1'b1;
    end
    // FSM-driven sets come after the clear so a same-cycle clear cannot hide them.
    if (exec_cmd && ((state_q != StIdle) || !tn_ok)) begin
      status_d[status_index_error_w_execute_cfg] = 1'b1;
    end
    if (running && !test_done && wd_expired) begin
      abort_d = 1'b1;
      status_d[status_index_error_w_execute_cfg] = 1'b1;
    end
    if (state_q == StDone) status_d[test_done_index(run_tn_q)] = 1'b1;
    if (rst_cmd) begin
      cfg0_d   = '0;
      cfg1_d   = '0;
      exec_d   = '0;
      status_d = '0;
      status_d[status_index_op_code_w_rst_fw] = 1'b1;
      abort_d  = running;
    end
  end

  always_ff @(posedge fw_axi_clk or posedge fw_rst) begin
    if (fw_rst) begin
      ready_q    <= 1'b0;
      cfg0_q     <= '0;
      cfg1_q     <= '0;
      exec_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      arr_wr_q   <= 1'b0;
      arr_rd_q   <= 1'b0;
      arr_sel_q  <= '0;
      arr_body_q <= '0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      run_tn_q   <= '0;
      status_q   <= '0;
    end else begin
      ready_q    <= 1'b1;
      cfg0_q     <= cfg0_d;
      cfg1_q     <= cfg1_d;
      exec_q     <= exec_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      arr_wr_q   <= arr_wr_d;
      arr_rd_q   <= arr_rd_d;
      arr_sel_q  <= arr_sel_d;
      arr_body_q <= arr_body_d;
      start_q    <= start_d;
      abort_q    <= abort_d;
      run_tn_q   <= run_tn_d;
      status_q   <= status_d;
    end
  end

  assign cmd_ready        = ready_q;
  assign cfg_static_0_reg = cfg0_q;
  assign cfg_static_1_reg = cfg1_q;
  assign execute_cfg_reg  = exec_q;
  assign rd_data          = rd_data_q;
  assign rd_valid         = rd_valid_q;
  assign arr_wr           = arr_wr_q;
  assign arr_rd           = arr_rd_q;
  assign arr_sel          = arr_sel_q;
  assign arr_body         = arr_body_q;
  assign test_start       = start_q;
  assign test_abort       = abort_q;
  assign status_reg       = status_q;

endmodule

// File: doc/fw_cmd_dispatcher.md
FW_CMD_DISPATCHER -- requirements
Module: fw_cmd_dispatcher

Interface
REQ-001 Parameter TIMEOUT_W, default 24: width of the execute watchdog counter.
REQ-002 Parameter FW_ID, default 4'h1: one-hot firmware id of this instance (firmware_id_1..4).
REQ-003 fw_axi_clk  in  1  sole clock (AXI 100MHz domain).
REQ-004 fw_rst  in  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  in  1 / cmd_ready  out  1 / cmd_word  in  32  command handshake; word = device_id[31:28], op_code[27:24], body[23:0].
REQ-006 cfg_static_0_reg, cfg_static_1_reg, execute_cfg_reg  out  24 each  latched configuration.
REQ-007 rd_data  out  32 / rd_valid  out  1  read-back return.
REQ-008 arr_wr, arr_rd  out  1 each  one-cycle array-access strobes; arr_sel  out  3 (0..2 cfg_array_0..2, 3..4 data_array_0..1); arr_body  out  24.
REQ-009 test_start  out  1  one-cycle pulse; test_abort  out  1  one-cycle pulse; test_done  in  1  pulse from the selected test engine.
REQ-010 status_reg  out  32  sticky status bits, indices per shared package.

Function
REQ-011 Accept = cmd_valid & cmd_ready; cmd_ready SHALL be 1 in every state except out of reset cycle 0 (deasserted only while fw_rst is high).
REQ-012 Match = (cmd_word[31:28] & FW_ID) != 0; unmatched accepted commands SHALL be consumed with no effect.
REQ-013 All effects of a matched command SHALL appear on outputs the cycle after accept (latency 1).
REQ-014 W_CFG_STATIC_0/1 SHALL load body into the corresponding register; W_EXECUTE SHALL load execute_cfg_reg.
REQ-015 R_CFG_STATIC_0/1 SHALL drive rd_data={8'h00,reg} with rd_valid pulse for one cycle.
REQ-016 W/R_CFG_ARRAY_n and R_DATA_ARRAY_n SHALL pulse arr_wr or arr_rd with arr_sel and arr_body=body.
REQ-017 Each matched op except NOOP, W_RST_FW, W_STATUS_FW_CLEAR SHALL set its status_index_op_code_* bit.
REQ-018 FSM states IDLE, RUN, DONE; IDLE->RUN on matched W_EXECUTE with valid test number, pulsing test_start.
REQ-019 Valid test numbers (body[15:12], IP2 field position) are 1,2,4,8,3; any other value SHALL set bit 31 (error_w_execute_cfg), no start, stay IDLE.
REQ-020 RUN: watchdog counts up from 0 each cycle; test_done -> DONE; counter reaching all-ones -> set bit 31, pulse test_abort, -> IDLE.
REQ-021 DONE (one cycle): set status_index_testN_done for the running test number (1->14, 2->15, 4->16, 8->17, 3->18), -> IDLE.
REQ-022 Matched W_EXECUTE while in RUN or DONE SHALL set bit 31, be dropped, and not alter execute_cfg_reg.
REQ-023 Matched W_RST_FW in any state SHALL clear all cfg registers and status, set bit 0, pulse test_abort if in RUN, and go IDLE.
REQ-024 W_STATUS_FW_CLEAR SHALL zero status_reg; a status set in the same cycle (test done, error) SHALL win over the clear.
REQ-025 test_done outside RUN SHALL be ignored.
REQ-026 Other ops accepted during RUN SHALL execute normally without disturbing the FSM.

Reset
REQ-027 On fw_rst: state IDLE, all cfg registers 0, status_reg 0, watchdog 0, rd_data 0, all strobes/pulses 0, cmd_ready 0.
REQ-028 Reset asserted mid-RUN SHALL not emit test_abort; engines are reset by the same fw_rst.

Structure
REQ-029 op_code enum, status_index_* constants, test_number_* constants, firmware_id_* constants and the dispatcher FSM state enum SHALL live in cms_pix28_package.
REQ-030 Watchdog counter SHALL be a sub-module fw_cmd_watchdog (clear, enable, expired outputs).

Verification
REQ-031 cmd 0x12ABCDEF (id 1, W_CFG_STATIC_0) -> next cycle cfg_static_0_reg=0xABCDEF, status bit1=1; then 0x13000000 -> rd_data=0x00ABCDEF, rd_valid one cycle.
REQ-032 cmd 0x2F001000 with FW_ID=1 -> no output change, status unchanged.
REQ-033 cmd 0x1F001000 -> test_start pulse, bit13 set; test_done 10 cycles later -> bit14 set, FSM IDLE.
REQ-034 cmd 0x1F005000 (test 5, invalid) -> bit31 set, no test_start.
REQ-035 TIMEOUT_W=4, start test, withhold test_done -> test_abort after 15 cycles, bit31 set; second W_EXECUTE during RUN -> bit31 set, execute_cfg_reg unchanged.
REQ-036 W_STATUS_FW_CLEAR accepted same cycle FSM in DONE for test 2 -> status_reg=0x00008000; W_RST_FW during RUN -> test_abort, status_reg=0x00000001.
